// File: rtl/block_check_pkg.sv
// ============================================================================
// block_check_pkg - shared types and constants for the block-check scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package block_check_pkg;

    localparam int CHAR_W = 8;
    localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4,
        REPORT = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/char_buffer.sv
// ============================================================================
// char_buffer - DEPTH x CHAR_W string store with write/read pointers and count
// Revision: 1.0
// ============================================================================
`default_nettype none

module char_buffer
    import block_check_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [CHAR_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic              clr_i,
    output logic [CHAR_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              rd_last_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;

    assign full_o    = (count_q == CW'(DEPTH));
    assign push      = wr_en_i && !full_o;
    assign rd_data_o = mem[rd_q];
    assign rd_last_o = (CW'(rd_q) == (count_q - CW'(1)));

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= wr_data_i;
        end
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clr_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wr_d    = wr_q + AW'(1);
                count_d = count_q + CW'(1);
            end
            if (rd_en_i) begin
                rd_d = rd_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/block_check_scheduler.sv
// ============================================================================
// block_check_scheduler - round-robin sharing of one BlockChecker among NREQ
// character-stream requesters; buffers, replays and reports per string.
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_check_scheduler
    import block_check_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 16,
    parameter int IDW   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        in_valid,
    input  logic [CHAR_W*NREQ-1:0] in_data,
    input  logic [NREQ-1:0]        in_last,
    output logic [NREQ-1:0]        in_ready,
    output logic                   chk_clear,
    output logic [CHAR_W-1:0]      chk_in,
    input  logic                   chk_result,
    output logic                   done_valid,
    output logic [IDW-1:0]         done_id,
    output logic                   done_result,
    output logic                   done_err,
    output logic                   busy
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic              err_q, err_d;
    logic              res_q, res_d;

    logic              sel_valid, sel_last;
    logic [CHAR_W-1:0] sel_data;
    logic              buf_wr_en, buf_rd_en, buf_clr;
    logic              buf_full, buf_rd_last;
    logic [CHAR_W-1:0] buf_rd_data;

    // Lowest asserted index at or after ptr, wrapping to the bottom if none.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic           found;
        pick  = ptr;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i] && (i >= int'(ptr))) begin
                pick  = IDW'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (v[i]) begin
                    pick = IDW'(i);
                end
            end
        end
        return pick;
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = CHAR_SPACE;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*CHAR_W +: CHAR_W];
            end
        end
    end

    char_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (buf_wr_en),
        .wr_data_i (sel_data),
        .rd_en_i   (buf_rd_en),
        .clr_i     (buf_clr),
        .rd_data_o (buf_rd_data),
        .full_o    (buf_full),
        .rd_last_o (buf_rd_last)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        err_d       = err_q;
        res_d       = res_q;
        in_ready    = '0;
        chk_clear   = 1'b0;
        chk_in      = CHAR_SPACE;
        done_valid  = 1'b0;
        done_id     = '0;
        done_result = 1'b0;
        done_err    = 1'b0;
        buf_wr_en   = 1'b0;
        buf_rd_en   = 1'b0;
        buf_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    grant_d = rr_pick(in_valid, rr_q);
                    rr_d    = (grant_d == IDW'(NREQ - 1)) ? '0 : grant_d + IDW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                for (int i = 0; i < NREQ; i++) begin
                    in_ready[i] = (grant_q == IDW'(i));
                end
                // Overflow beats are still accepted so the producer can finish its string.
                if (sel_valid) begin
                    buf_wr_en = 1'b1;
                    if (buf_full) begin
                        err_d = 1'b1;
                    end
                    if (sel_last) begin
                        state_d = (err_q || buf_full) ? REPORT : CLEAR;
                    end
                end
            end
            CLEAR: begin
                chk_clear = 1'b1;
                state_d   = STREAM;
            end
            STREAM: begin
                chk_in    = buf_rd_data;
                buf_rd_en = 1'b1;
                if (buf_rd_last) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                res_d   = chk_result;
                state_d = REPORT;
            end
            REPORT: begin
                done_valid  = 1'b1;
                done_id     = grant_q;
                done_result = res_q & ~err_q;
                done_err    = err_q;
                buf_clr     = 1'b1;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_block_check_scheduler.sv
// ============================================================================
// tb_block_check_scheduler - scenario bench with a behavioural BlockChecker
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_block_check_scheduler;

    localparam int NREQ  = 2;
    localparam int DEPTH = 16;
    localparam int IDW   = 1;
    localparam logic [7:0] SP = 8'h20;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     in_valid = '0;
    logic [8*NREQ-1:0]   in_data = '0;
    logic [NREQ-1:0]     in_last = '0;
    logic [NREQ-1:0]     in_ready;
    logic                chk_clear;
    logic [7:0]          chk_in;
    logic                chk_result;
    logic                done_valid;
    logic [IDW-1:0]      done_id;
    logic                done_result;
    logic                done_err;
    logic                busy;

    int n_cmp = 0;
    int n_fail = 0;
    int pcount = 0;

    typedef struct {
        int id;
        bit res;
        bit err;
        int p;
    } done_t;

    done_t      done_q[$];
    logic [7:0] chk_hist[int];
    bit         clr_hist[int];

    block_check_scheduler #(.NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .chk_clear(chk_clear),
        .chk_in(chk_in), .chk_result(chk_result), .done_valid(done_valid),
        .done_id(done_id), .done_result(done_result), .done_err(done_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcount++;

    always @(negedge clk) begin : mon
        done_t d;
        chk_hist[pcount] = chk_in;
        clr_hist[pcount] = chk_clear;
        if (done_valid) begin
            d.id  = int'(done_id);
            d.res = done_result;
            d.err = done_err;
            d.p   = pcount;
            done_q.push_back(d);
        end
    end

    // Behavioural BlockChecker: case-insensitive begin/end nesting over space-separated words.
    int          ck_depth = 0;
    bit          ck_bad = 1'b0;
    logic [47:0] ck_w = '0;
    int          ck_len = 0;
    logic        ck_is_begin, ck_is_end;

    function automatic logic [7:0] lc(input logic [7:0] c);
        return (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    endfunction

    assign ck_is_begin = (ck_len == 5) && (ck_w[39:0] == "begin");
    assign ck_is_end   = (ck_len == 3) && (ck_w[23:0] == "end");
    assign chk_result  = !ck_bad && !(ck_is_end && ck_depth == 0) &&
                         ((ck_depth + (ck_is_begin ? 1 : 0) - (ck_is_end ? 1 : 0)) == 0);

    always @(posedge clk) begin
        if (chk_clear) begin
            ck_depth <= 0; ck_bad <= 1'b0; ck_len <= 0; ck_w <= '0;
        end else if (chk_in == SP) begin
            if (ck_is_begin) ck_depth <= ck_depth + 1;
            else if (ck_is_end) begin
                if (ck_depth == 0) ck_bad <= 1'b1;
                else ck_depth <= ck_depth - 1;
            end
            ck_len <= 0; ck_w <= '0;
        end else begin
            ck_w   <= {ck_w[39:0], lc(chk_in)};
            ck_len <= ck_len + 1;
        end
    end

    function automatic bit ref_verdict(input string s);
        int    depth = 0;
        bit    bad = 1'b0;
        string w = "";
        string t = {s.tolower(), " "};
        for (int i = 0; i < t.len(); i++) begin
            if (t[i] == SP) begin
                if (w == "begin") depth++;
                else if (w == "end") begin
                    if (depth == 0) bad = 1'b1;
                    else depth--;
                end
                w = "";
            end else begin
                w = {w, t.substr(i, i)};
            end
        end
        return !bad && depth == 0;
    endfunction

    function automatic string tok(input int k);
        case (k)
            0: return "begin";
            1: return "end";
            2: return "BEGIN";
            3: return "End";
            4: return "x";
            default: return "beginx";
        endcase
    endfunction

    task automatic send_string(input int r, input string s, input int stall_at, input int stall_len,
                               output int s0, output int e0, output bit ok);
        int t;
        ok = 1'b1; s0 = -1; e0 = -1;
        for (int i = 0; i < s.len(); i++) begin
            if (i == stall_at) begin
                in_valid[r] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            in_valid[r] = 1'b1;
            in_data[r*8 +: 8] = s[i];
            in_last[r] = (i == s.len() - 1);
            t = 0;
            @(negedge clk);
            while (!in_ready[r]) begin
                t++;
                if (t > 400) begin
                    n_cmp++; n_fail++;
                    $display("FAIL accept_timeout req%0d char %0d: in_ready=0, required 1", r, i);
                    ok = 1'b0; in_valid[r] = 1'b0; in_last[r] = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            if (i == 0) s0 = pcount + 1;
            if (i == s.len() - 1) e0 = pcount + 1;
            @(posedge clk); #1;
        end
        in_valid[r] = 1'b0; in_last[r] = 1'b0;
    endtask

    task automatic wait_done(output done_t d, output bit ok);
        ok = 1'b0;
        d.id = -1; d.res = 1'b0; d.err = 1'b0; d.p = -1;
        for (int t = 0; t < 300; t++) begin
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                ok = 1'b1;
                return;
            end
            @(negedge clk); #1;
        end
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: done_valid never seen, required one strobe");
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== '0) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        n_cmp++; if (chk_clear !== 1'b0) begin n_fail++; $display("FAIL rst_chk_clear: got %b, required 0", chk_clear); end
        n_cmp++; if (chk_in !== SP) begin n_fail++; $display("FAIL rst_chk_in: got %h, required 20", chk_in); end
        n_cmp++; if ({done_valid, done_id, done_result, done_err} !== '0) begin n_fail++;
            $display("FAIL rst_done: got v%b id%0d r%b e%b, required all 0", done_valid, done_id, done_result, done_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_basic;
        string s = "begin end";
        int s0, e0, nclr;
        bit ok, dok;
        done_t d;
        send_string(0, s, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        if (ok && dok) begin
            nclr = 0;
            for (int p = s0; p <= d.p; p++) nclr += int'(clr_hist[p]);
            n_cmp++; if (nclr != 1 || clr_hist[e0] !== 1'b1) begin n_fail++;
                $display("FAIL basic_clear: %0d pulses (at E0+1: %b), required 1 in cycle E0+1", nclr, clr_hist[e0]); end
            for (int k = 0; k < s.len(); k++) begin
                n_cmp++; if (chk_hist[e0+1+k] !== s[k]) begin n_fail++;
                    $display("FAIL basic_chk_in[%0d]: got %h, required %h", k, chk_hist[e0+1+k], s[k]); end
            end
            n_cmp++; if (chk_hist[e0+s.len()+1] !== SP) begin n_fail++;
                $display("FAIL basic_flush_space: got %h, required 20", chk_hist[e0+s.len()+1]); end
            n_cmp++; if (d.p - e0 + 1 != s.len() + 3) begin n_fail++;
                $display("FAIL basic_latency: done at E0+%0d, required E0+%0d", d.p - e0 + 1, s.len() + 3); end
            n_cmp++; if (d.id != 0 || d.res !== ref_verdict(s) || d.err !== 1'b0) begin n_fail++;
                $display("FAIL basic_done: id%0d r%b e%b, required id0 r%b e0", d.id, d.res, d.err, ref_verdict(s)); end
        end
    endtask

    task automatic test_words;
        string s1 = "BeGin";
        string s2 = "end begin";
        int s0, e0;
        bit ok, dok;
        done_t d;
        send_string(1, s1, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        n_cmp++; if (!dok || d.id != 1 || d.res !== ref_verdict(s1) || d.err !== 1'b0) begin n_fail++;
            $display("FAIL mixed_case: id%0d r%b e%b, required id1 r%b e0", d.id, d.res, d.err, ref_verdict(s1)); end
        send_string(0, s2, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        n_cmp++; if (!dok || d.id != 0 || d.res !== ref_verdict(s2) || d.err !== 1'b0) begin n_fail++;
            $display("FAIL unmatched_end: id%0d r%b e%b, required id0 r%b e0", d.id, d.res, d.err, ref_verdict(s2)); end
    endtask

    task automatic test_simultaneous;
        string sa = "begin end";
        string sb = "begin";
        string sc = "end";
        int s0a, e0a, s0b, e0b, s0c, e0c;
        bit oka, okb, okc, dok;
        int    exp_id[3];
        string exp_s[3];
        done_t d;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        exp_id = '{0, 1, 0};
        exp_s[0] = sa; exp_s[1] = sb; exp_s[2] = sc;
        fork
            begin
                send_string(0, sa, -1, 0, s0a, e0a, oka);
                send_string(0, sc, -1, 0, s0c, e0c, okc);
            end
            send_string(1, sb, -1, 0, s0b, e0b, okb);
        join
        for (int k = 0; k < 3; k++) begin
            wait_done(d, dok);
            n_cmp++; if (!dok || d.id != exp_id[k] || d.res !== ref_verdict(exp_s[k])) begin n_fail++;
                $display("FAIL rr_order[%0d]: id%0d r%b, required id%0d r%b", k, d.id, d.res, exp_id[k], ref_verdict(exp_s[k])); end
        end
    endtask

    task automatic test_overflow;
        string s = "";
        string s16 = "begin end xxxxxx";
        int s0, e0, nclr;
        bit ok, dok;
        done_t d;
        for (int i = 0; i < 20; i++) s = {s, (i % 3 == 2) ? " " : "q"};
        send_string(0, s, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        if (ok && dok) begin
            nclr = 0;
            for (int p = s0; p <= d.p; p++) nclr += int'(clr_hist[p]);
            n_cmp++; if (nclr != 0) begin n_fail++; $display("FAIL ovf_clear: %0d pulses, required 0", nclr); end
            n_cmp++; if (d.p != e0 || d.err !== 1'b1 || d.res !== 1'b0 || d.id != 0) begin n_fail++;
                $display("FAIL ovf_done: at E0+%0d id%0d r%b e%b, required E0+1 id0 r0 e1", d.p - e0 + 1, d.id, d.res, d.err); end
        end
        send_string(0, s16, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        n_cmp++; if (!dok || d.err !== 1'b0 || d.res !== ref_verdict(s16) || d.p - e0 + 1 != 19) begin n_fail++;
            $display("FAIL full_depth: at E0+%0d r%b e%b, required E0+19 r%b e0", d.p - e0 + 1, d.res, d.err, ref_verdict(s16)); end
    endtask

    task automatic test_stall;
        string s = "begin end";
        int s0, e0, bad;
        bit ok, dok;
        done_t d;
        send_string(0, s, 3, 5, s0, e0, ok);
        wait_done(d, dok);
        if (ok && dok) begin
            n_cmp++; if (e0 - s0 != s.len() - 1 + 5) begin n_fail++;
                $display("FAIL stall_span: first-to-last accept %0d cycles, required %0d", e0 - s0, s.len() + 4); end
            bad = 0;
            for (int p = s0; p < e0; p++) if (chk_hist[p] !== SP || clr_hist[p] !== 1'b0) bad++;
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL stall_quiet: %0d busy checker cycles, required 0", bad); end
            n_cmp++; if (d.res !== ref_verdict(s) || d.err !== 1'b0 || d.p - e0 + 1 != s.len() + 3) begin n_fail++;
                $display("FAIL stall_done: r%b e%b at E0+%0d, required r%b e0 E0+%0d", d.res, d.err, d.p - e0 + 1, ref_verdict(s), s.len() + 3); end
        end
    endtask

    task automatic test_reset_mid_stream;
        string s = "begin end begin";
        string s2 = "begin end";
        int s0, e0, n0;
        bit ok, dok;
        done_t d;
        send_string(0, s, -1, 0, s0, e0, ok);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n0 = done_q.size();
        n_cmp++; if (in_ready !== '0 || chk_clear !== 1'b0 || chk_in !== SP || busy !== 1'b0 ||
                     {done_valid, done_id, done_result, done_err} !== '0) begin n_fail++;
            $display("FAIL midrst_outputs: rdy%b clr%b in%h busy%b done%b, required 0 0 20 0 0",
                     in_ready, chk_clear, chk_in, busy, done_valid); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (done_q.size() != n0) begin n_fail++;
            $display("FAIL midrst_no_done: %0d strobes, required 0", done_q.size() - n0); end
        send_string(1, s2, -1, 0, s0, e0, ok);
        wait_done(d, dok);
        n_cmp++; if (!dok || d.id != 1 || d.res !== ref_verdict(s2) || d.err !== 1'b0) begin n_fail++;
            $display("FAIL midrst_next: id%0d r%b e%b, required id1 r%b e0", d.id, d.res, d.err, ref_verdict(s2)); end
    endtask

    task automatic test_random;
        string s;
        int r, n, s0, e0, stall_at, exp_p;
        bit ok, dok, exp_err, exp_res;
        done_t d;
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, NREQ - 1);
            n = $urandom_range(1, 4);
            s = "";
            for (int j = 0; j < n; j++) begin
                if (j > 0) s = {s, " "};
                s = {s, tok($urandom_range(0, 5))};
            end
            stall_at = ($urandom_range(0, 3) == 0 && s.len() > 1) ? $urandom_range(1, s.len() - 1) : -1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_string(r, s, stall_at, $urandom_range(1, 4), s0, e0, ok);
            wait_done(d, dok);
            exp_err = (s.len() > DEPTH);
            exp_res = exp_err ? 1'b0 : ref_verdict(s);
            exp_p   = exp_err ? e0 : e0 + s.len() + 2;
            n_cmp++; if (!dok || d.id != r || d.res !== exp_res || d.err !== exp_err || d.p != exp_p) begin n_fail++;
                $display("FAIL rand[%0d] \"%s\": id%0d r%b e%b p%0d, required id%0d r%b e%b p%0d",
                         it, s, d.id, d.res, d.err, d.p, r, exp_res, exp_err, exp_p); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_words();
        test_simultaneous();
        test_overflow();
        test_stall();
        test_reset_mid_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/block_check_scheduler.md
Name: block_check_scheduler

Overview:
- Shares one BlockChecker instance between NREQ character-stream requesters.
- Arbitrates round-robin per whole string, buffers the granted string, clears the checker, then streams the buffered characters gap-free, one per cycle.
- After the last character it samples the checker verdict and returns it to the owning requester.
- Sits between producer front-ends and the checker's clk/reset/in/result interface.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DEPTH, 16, max characters per string held in the buffer.
- IDW, 1, width of requester id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NREQ  per-requester character valid.
- in_data  input  8*NREQ  per-requester ASCII character; slice i is [8i+7:8i].
- in_last  input  NREQ  marks the final character of a string.
- in_ready  output  NREQ  character accepted when valid&ready.
- chk_clear  output  1  drives the checker reset; one-cycle pulse.
- chk_in  output  8  drives the checker in.
- chk_result  input  1  checker result; combinational from the checker state.
- done_valid  output  1  one-cycle verdict strobe.
- done_id  output  IDW  requester the verdict belongs to.
- done_result  output  1  checker verdict; forced 0 on error.
- done_err  output  1  string exceeded DEPTH.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=0, chk_clear=0, chk_in=8'h20 (space), done_*=0, busy=0, rr pointer=0 (requester 0 has top priority), buffer count=0, err=0.
- Reset is honoured in any state; mid-string data is discarded and no done is issued.
- IDLE:
  - Grant the lowest index at or after rr among asserted in_valid.
  - rr <= grant+1, wrapping mod NREQ.
  - Go to LOAD the next cycle. No beat is accepted in IDLE.
- LOAD:
  - in_ready is high only for the granted requester.
  - Each accepted beat is written to buf[wr], wr++ while count<DEPTH.
  - If count==DEPTH, the beat is dropped and err<=1; in_ready stays high until in_last is accepted.
  - Accepting in_last moves to CLEAR if err=0, otherwise to REPORT.
  - The granted requester may deassert valid mid-string. LOAD waits indefinitely and nothing reaches the checker.
- CLEAR: chk_clear=1 for exactly one cycle; chk_in=space. Then go to STREAM with rd=0.
- STREAM: chk_in=buf[rd] each cycle, rd++. After presenting buf[count-1], go to FLUSH.
- FLUSH:
  - chk_in=space.
  - At the end of this cycle, latch res<=chk_result; this reflects the state after the last character.
  - Go to REPORT.
- REPORT:
  - done_valid=1, done_id=grant, done_result=res&~err, done_err=err.
  - Clear count, err, wr, rd. Go to IDLE.
- chk_in is space in every state other than STREAM. Spaces between strings are harmless to the checker.
- Latency: with L = string length and edge E0 accepting in_last, the clear pulse occupies cycle 1 after E0. Characters occupy cycles 2..L+1, FLUSH is L+2, and done_valid is in cycle L+3.
- Error path: REPORT comes 1 cycle after E0, with done_result=0 and done_err=1.
- Simultaneous valids in IDLE are resolved purely by rr. Losers see in_ready=0 and must hold their data.
- L=1 is legal: STREAM lasts one cycle.
- A string of exactly DEPTH characters is not an error.

Decomposition:
- Package block_check_pkg holds:
  - state enum {IDLE, LOAD, CLEAR, STREAM, FLUSH, REPORT};
  - CHAR_SPACE=8'h20;
  - CHAR_W=8.
- Sub-module char_buffer holds DEPTH x 8 storage with wr/rd pointers and count. It has no reset on data, and pointers are reset asynchronously.
- Arbitration, FSM and handshake logic stay in the top module.

Test Plan:
- Req0 sends "begin end" (9 chars) with req1 idle:
  - chk_clear pulses once;
  - chk_in shows b,e,g,i,n,' ',e,n,d on consecutive cycles;
  - done_valid at E0+12 with done_id=0, done_result=1, done_err=0.
- Req1 sends "BeGin" -> done_id=1, done_result=0. Req0 then sends "end begin" -> done_result=0, since an unmatched end is irrecoverable.
- Both requesters assert valid in the same cycle after reset:
  - req0 is granted first, and its done precedes req1's;
  - for a second simultaneous round, req1 is granted first (rr rotation).
- Req0 sends 20 chars with DEPTH=16:
  - all 20 beats are accepted;
  - chk_clear never pulses;
  - done_err=1 and done_result=0 at E0+1.
- Req0 stalls in_valid for 5 cycles mid-"begin":
  - chk_in stays space and chk_clear stays 0 during the stall;
  - the final verdict equals the unstalled case.
- Assert reset during STREAM:
  - all outputs return to reset values immediately;
  - no done_valid occurs;
  - the next string from req1 is granted and checked correctly.
